// File: rtl/zx_pkg.sv
// Shared constants for the 128K/+3 style memory pager: I/O port addresses,
// paging-register bit positions, the all-RAM slot map and port decode helpers.
package zx_pkg;

  localparam logic [15:0] PORT_FE   = 16'h00FE;
  localparam logic [15:0] PORT_7FFD = 16'h7FFD;
  localparam logic [15:0] PORT_1FFD = 16'h1FFD;

  // 7FFD layout
  localparam int P7_BANK_LO = 0;
  localparam int P7_SCREEN  = 3;
  localparam int P7_ROM     = 4;
  localparam int P7_LOCK    = 5;
  localparam int P7_BANK_HI = 6;

  // 1FFD layout
  localparam int P1_SPECIAL = 0;
  localparam int P1_CFG     = 1;
  localparam int P1_ROM_HI  = 2;

  localparam logic [2:0] BANK_SCREEN = 3'd5;
  localparam logic [2:0] BANK_MID    = 3'd2;

  // One row per special config; slot s occupies bits [3s+2:3s].
  localparam logic [3:0][11:0] SPECIAL_MAP = {
    {3'd3, 3'd6, 3'd7, 3'd4},
    {3'd3, 3'd6, 3'd5, 3'd4},
    {3'd7, 3'd6, 3'd5, 3'd4},
    {3'd3, 3'd2, 3'd1, 3'd0}
  };

  function automatic logic [2:0] special_bank(input logic [1:0] cfg, input logic [1:0] slot);
    return SPECIAL_MAP[cfg][3*slot +: 3];
  endfunction

  // The ULA port only looks at A0.
  function automatic logic hit_fe(input logic a0);
    return a0 == PORT_FE[0];
  endfunction

  function automatic logic hit_7ffd(input logic [15:0] a, input logic full);
    if (full) return a == PORT_7FFD;
    return (a[15] == PORT_7FFD[15]) && (a[1] == PORT_7FFD[1]);
  endfunction

  function automatic logic hit_1ffd(input logic [15:0] a, input logic full);
    if (full) return a == PORT_1FFD;
    return (a[15:12] == PORT_1FFD[15:12]) && (a[1] == PORT_1FFD[1]);
  endfunction

endpackage

// File: rtl/zx_io_strobe.sv
// Synchronises the async CPU strobes and emits one registered write pulse per OUT
// cycle together with the held A/D; pulse lands 3 clocks after nWR falls, no backpressure.
module zx_io_strobe (
  input  logic        clock_25,
  input  logic        RESET_N,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  output logic        wr_evt,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);

  logic [1:0] iorq_s;
  logic [1:0] rd_s;
  logic [1:0] wr_s;
  logic       io_wr;
  logic       io_wr_q;
  logic [1:0] settle;

  assign io_wr = ~iorq_s[1] & rd_s[1] & ~wr_s[1];

  // settle blocks the first edges after reset so a strobe that was already
  // active while in reset never counts as a fresh write.
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      iorq_s  <= 2'b11;
      rd_s    <= 2'b11;
      wr_s    <= 2'b11;
      io_wr_q <= 1'b0;
      settle  <= 2'd3;
      wr_evt  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      iorq_s  <= {iorq_s[0], nIORQ};
      rd_s    <= {rd_s[0], nRD};
      wr_s    <= {wr_s[0], nWR};
      io_wr_q <= io_wr;
      if (settle != 2'd0) settle <= settle - 2'd1;
      wr_evt  <= io_wr & ~io_wr_q & (settle == 2'd0);
      if (!wr_s[1]) begin
        wr_addr <= A;
        wr_data <= D;
      end
    end
  end

endmodule

// File: rtl/zx_pager.sv
// 128K/+3 style paging: decodes OUT to FE/7FFD/1FFD into paging registers and maps
// the live CPU address to RAM/ROM combinationally; register change 3-4 clocks after nWR, no backpressure.
module zx_pager
  import zx_pkg::*;
#(
  parameter int RAM_BANK_BITS = 3,
  parameter int FULL_DECODE   = 0,
  parameter int EXT_PORT_EN   = 0
) (
  input  logic                        clock_25,
  input  logic                        RESET_N,
  input  logic [15:0]                 A,
  input  logic [7:0]                  D,
  input  logic                        nIORQ,
  input  logic                        nRD,
  input  logic                        nWR,
  output logic [14+RAM_BANK_BITS-1:0] ram_addr,
  output logic [15:0]                 rom_addr,
  output logic                        is_rom,
  output logic                        mem_we,
  output logic                        scr_bank,
  output logic [2:0]                  border,
  output logic                        paging_locked
);

  logic        wr_evt;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  zx_io_strobe u_io_strobe (
    .clock_25 (clock_25),
    .RESET_N  (RESET_N),
    .A        (A),
    .D        (D),
    .nIORQ    (nIORQ),
    .nRD      (nRD),
    .nWR      (nWR),
    .wr_evt   (wr_evt),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  logic [7:0] p7ffd;
  logic [2:0] p1ffd;
  logic       sel_fe;
  logic       sel_7ffd;
  logic       sel_1ffd;
  logic       locked;

  assign sel_fe   = hit_fe(wr_addr[0]);
  assign sel_7ffd = hit_7ffd(wr_addr, FULL_DECODE != 0);
  assign sel_1ffd = (EXT_PORT_EN != 0) && hit_1ffd(wr_addr, FULL_DECODE != 0);
  assign locked   = p7ffd[P7_LOCK];

  // Both paging ports check the lock as it stood before this write, so an
  // address hitting several ports updates them all consistently.
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      p7ffd  <= '0;
      p1ffd  <= '0;
      border <= '0;
    end else if (wr_evt) begin
      if (sel_fe) border <= wr_data[2:0];
      if (!locked && sel_7ffd) p7ffd <= wr_data;
      if (!locked && sel_1ffd) p1ffd <= wr_data[2:0];
    end
  end

  logic [1:0]               slot;
  logic [4:0]               sel_wide;
  logic [RAM_BANK_BITS-1:0] sel_bank;
  logic [RAM_BANK_BITS-1:0] bank;

  assign slot     = A[15:14];
  assign sel_wide = {p7ffd[P7_BANK_HI +: 2], p7ffd[P7_BANK_LO +: 3]};
  assign sel_bank = RAM_BANK_BITS'(sel_wide);

  always_comb begin
    bank   = '0;
    is_rom = 1'b0;
    if (p1ffd[P1_SPECIAL]) begin
      bank = RAM_BANK_BITS'(special_bank(p1ffd[P1_CFG +: 2], slot));
    end else begin
      case (slot)
        2'd0:    is_rom = 1'b1;
        2'd1:    bank = RAM_BANK_BITS'(BANK_SCREEN);
        2'd2:    bank = RAM_BANK_BITS'(BANK_MID);
        default: bank = sel_bank;
      endcase
    end
  end

  assign ram_addr      = {bank, A[13:0]};
  assign rom_addr      = {p1ffd[P1_ROM_HI], p7ffd[P7_ROM], A[13:0]};
  // Raw strobes keep the write enable inside the CPU's own timing window.
  assign mem_we        = nIORQ & nRD & ~nWR & ~is_rom;
  assign scr_bank      = p7ffd[P7_SCREEN];
  assign paging_locked = p7ffd[P7_LOCK];

endmodule
